// File: rtl/tx_arbiter_if.sv
// Bundles the requester-side and avr_interface-side signals of tx_arbiter.
// master = sources/board/avr side, slave = the arbiter itself.
interface tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic                   enable;
    logic [NUM_REQ-1:0]     req;
    logic [8*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ-1:0]     req_ack;
    logic [NUM_REQ-1:0]     grant;
    logic [7:0]             tx_data;
    logic                   new_tx_data;
    logic                   tx_busy;
    logic                   timeout;

    modport master (
        output enable, req, req_data, req_last, tx_busy,
        input  req_ack, grant, tx_data, new_tx_data, timeout
    );

    modport slave (
        input  enable, req, req_data, req_last, tx_busy,
        output req_ack, grant, tx_data, new_tx_data, timeout
    );
endinterface

// File: rtl/tx_arbiter.sv
// Whole-message round-robin arbiter sharing the AVR serial TX path among NUM_REQ sources.
// Optional stall watchdog enabled by defining TX_ARBITER_TIMEOUT_EN.
module tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CTR_BITS       = 16
) (
    input  logic          clk,
    input  logic          rst,
    tx_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
        $error("tx_arbiter: NUM_REQ must be in 2..8");
    end
    if ((64'd1 << CTR_BITS) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_ctr_bits
        $error("tx_arbiter: CTR_BITS too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic                 r_last;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_req_ack;
    logic [7:0]           r_tx_data;
    logic                 r_new_tx_data;
    logic                 r_timeout;
`ifdef TX_ARBITER_TIMEOUT_EN
    logic [CTR_BITS-1:0]  r_ctr;
`endif

    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_vld;
    logic [IDX_W-1:0]     w_cand;

    // Cyclic successor of a requester index (NUM_REQ-1 wraps to 0).
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            next_idx = '0;
        end else begin
            next_idx = idx + IDX_W'(1);
        end
    endfunction

    // First requesting index at or after the round-robin pointer.
    always_comb begin
        w_pick_idx = r_rr_ptr;
        w_pick_vld = 1'b0;
        w_cand     = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_pick_vld && bus.req[w_cand]) begin
                w_pick_idx = w_cand;
                w_pick_vld = 1'b1;
            end else begin
                w_pick_vld = w_pick_vld;
            end
            w_cand = next_idx(w_cand);
        end
    end

    // Arbitration FSM with registered grant, strobe, ack and timeout outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_last        <= 1'b0;
            r_grant       <= '0;
            r_req_ack     <= '0;
            r_tx_data     <= 8'h00;
            r_new_tx_data <= 1'b0;
            r_timeout     <= 1'b0;
`ifdef TX_ARBITER_TIMEOUT_EN
            r_ctr         <= '0;
`endif
        end else begin
            r_req_ack     <= '0;
            r_new_tx_data <= 1'b0;
            r_timeout     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.enable && w_pick_vld) begin
                        r_owner <= w_pick_idx;
                        r_grant <= ONE_HOT0 << w_pick_idx;
                        r_state <= SEND;
`ifdef TX_ARBITER_TIMEOUT_EN
                        r_ctr   <= '0;
`endif
                    end else begin
                        r_grant <= '0;
                    end
                end
                SEND: begin
                    if (bus.req[r_owner] && !bus.tx_busy) begin
                        r_tx_data          <= bus.req_data[{r_owner, 3'b000} +: 8];
                        r_last             <= bus.req_last[r_owner];
                        r_new_tx_data      <= 1'b1;
                        r_req_ack[r_owner] <= 1'b1;
                        r_state            <= HOLD;
`ifdef TX_ARBITER_TIMEOUT_EN
                        r_ctr              <= '0;
`endif
                    end
`ifdef TX_ARBITER_TIMEOUT_EN
                    // Only an absent owner byte counts as a stall; tx_busy waits do not.
                    else if (!bus.req[r_owner]) begin
                        if (r_ctr == CTR_BITS'(TIMEOUT_CYCLES - 1)) begin
                            r_grant   <= '0;
                            r_rr_ptr  <= next_idx(r_owner);
                            r_timeout <= 1'b1;
                            r_state   <= IDLE;
                            r_ctr     <= '0;
                        end else begin
                            r_ctr     <= r_ctr + CTR_BITS'(1);
                        end
                    end
`endif
                    else begin
                        r_state <= SEND;
                    end
                end
                HOLD: begin
                    // One dead cycle while avr_interface raises tx_busy.
                    if (r_last) begin
                        r_grant  <= '0;
                        r_rr_ptr <= next_idx(r_owner);
                        r_state  <= IDLE;
                    end else begin
                        r_state  <= SEND;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.req_ack     = r_req_ack;
    assign bus.tx_data     = r_tx_data;
    assign bus.new_tx_data = r_new_tx_data;
    assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: requester queues feed the DUT, a transaction-level
// round-robin model predicts the byte stream on the TX port.
module tb_tx_arbiter;
    localparam int NUM = 4;
`ifdef TX_ARBITER_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 50000;
`endif

    typedef struct {
        int         cyc;
        int         idx;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             tb_enable;
    logic             tb_busy;
    logic [NUM-1:0]   tb_req;
    logic [NUM-1:0]   tb_last;
    logic [8*NUM-1:0] tb_data;

    tx_arbiter_if #(.NUM_REQ(NUM)) bus();
    assign bus.enable   = tb_enable;
    assign bus.tx_busy  = tb_busy;
    assign bus.req      = tb_req;
    assign bus.req_last = tb_last;
    assign bus.req_data = tb_data;

    tx_arbiter #(.NUM_REQ(NUM), .TIMEOUT_CYCLES(TO), .CTR_BITS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks;
    int n_fail;
    int cyc;
    int onehot_viol;
    int ack_viol;
    int busy_viol;
    int busy_mode;
    int busy_cnt;
    logic [8:0] src_q [NUM][$];
    ev_t        log_q[$];
    ev_t        exp_q[$];
    int         to_q[$];

    function automatic int owner(input logic [NUM-1:0] g);
        owner = -1;
        for (int i = 0; i < NUM; i++) if (g[i]) owner = i;
    endfunction

    function automatic void drive_srcs();
        for (int i = 0; i < NUM; i++) begin
            tb_req[i] = (src_q[i].size() != 0);
            if (src_q[i].size() != 0) begin
                tb_data[8*i +: 8] = src_q[i][0][7:0];
                tb_last[i]        = src_q[i][0][8];
            end else begin
                tb_data[8*i +: 8] = 8'h00;
                tb_last[i]        = 1'b0;
            end
        end
    endfunction

    function automatic void add_msg(input int i, input int len);
        for (int k = 0; k < len; k++)
            src_q[i].push_back({(k == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255))});
    endfunction

    // Round-robin at message granularity over the pending queues.
    function automatic void build_exp();
        logic [8:0] m [NUM][$];
        int p;
        int sel;
        bit done;
        ev_t e;
        exp_q.delete();
        for (int i = 0; i < NUM; i++) m[i] = src_q[i];
        p = 0;
        forever begin
            sel = -1;
            for (int k = 0; k < NUM; k++)
                if (sel < 0 && m[(p + k) % NUM].size() != 0) sel = (p + k) % NUM;
            if (sel < 0) break;
            done = 1'b0;
            while (!done) begin
                e.cyc  = 0;
                e.idx  = sel;
                e.data = m[sel][0][7:0];
                done   = m[sel][0][8];
                void'(m[sel].pop_front());
                exp_q.push_back(e);
            end
            p = (sel + 1) % NUM;
        end
    endfunction

    task automatic step();
        logic busy_before;
        logic [NUM-1:0] g;
        logic [NUM-1:0] a;
        ev_t e;
        busy_before = tb_busy;
        @(posedge clk);
        #1;
        cyc++;
        g = bus.grant;
        a = bus.req_ack;
        if ($countones(g) > 1) onehot_viol++;
        if (bus.new_tx_data) begin
            e.cyc  = cyc;
            e.idx  = owner(g);
            e.data = bus.tx_data;
            log_q.push_back(e);
            if (busy_before) busy_viol++;
            if (a != g) ack_viol++;
        end else if (a != '0) begin
            ack_viol++;
        end
        if (bus.timeout) to_q.push_back(cyc);
        for (int i = 0; i < NUM; i++)
            if (a[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        case (busy_mode)
            1: begin
                if (bus.new_tx_data) busy_cnt = 20;
                else if (busy_cnt > 0) busy_cnt--;
                tb_busy = (busy_cnt > 0);
            end
            2: tb_busy = ($urandom_range(0, 3) == 0);
            default: tb_busy = 1'b0;
        endcase
        drive_srcs();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM; i++) src_q[i].delete();
        drive_srcs();
        busy_mode = 0;
        busy_cnt  = 0;
        tb_busy   = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        log_q.delete();
        to_q.delete();
        onehot_viol = 0;
        ack_viol    = 0;
        busy_viol   = 0;
    endtask

    task automatic drain(input int budget, output bit ok);
        bit empty;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            step();
            empty = 1'b1;
            for (int i = 0; i < NUM; i++) if (src_q[i].size() != 0) empty = 1'b0;
            if (empty && bus.grant == '0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        tb_enable = 1'b1;
        for (int i = 0; i < NUM; i++) add_msg(i, 2);
        drive_srcs();
        rst = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({bus.grant, bus.req_ack, bus.tx_data, bus.new_tx_data, bus.timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got grant=%b ack=%b tx=%h strobe=%b to=%b, required all 0",
                     bus.grant, bus.req_ack, bus.tx_data, bus.new_tx_data, bus.timeout);
        end
        do_reset();
    endtask

    task automatic test_single();
        bit ok;
        logic [7:0] bytes_exp [3];
        bytes_exp[0] = 8'h41; bytes_exp[1] = 8'h42; bytes_exp[2] = 8'h43;
        do_reset();
        tb_enable = 1'b1;
        src_q[0].push_back(9'h041);
        src_q[0].push_back(9'h042);
        src_q[0].push_back(9'h143);
        drive_srcs();
        step();
        n_checks++;
        if (bus.grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant: got %b required 0001", bus.grant);
        end
        drain(50, ok);
        n_checks++;
        if (!ok || cyc != 7) begin
            n_fail++;
            $display("FAIL single_release: ok=%0d grant fell at cycle %0d, required 7", ok, cyc);
        end
        n_checks++;
        if (log_q.size() != 3) begin
            n_fail++;
            $display("FAIL single_count: got %0d strobes required 3", log_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (log_q[k].data !== bytes_exp[k] || log_q[k].idx != 0 || log_q[k].cyc != 2 + 2*k) begin
                    n_fail++;
                    $display("FAIL single_byte%0d: got %h from %0d at %0d, required %h from 0 at %0d",
                             k, log_q[k].data, log_q[k].idx, log_q[k].cyc, bytes_exp[k], 2 + 2*k);
                end
            end
        end
        n_checks++;
        if (ack_viol != 0) begin
            n_fail++;
            $display("FAIL single_ack_pairing: got %0d violations required 0", ack_viol);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        tb_enable = 1'b1;
        add_msg(0, 2);
        add_msg(2, 2);
        add_msg(3, 2);
        build_exp();
        drive_srcs();
        drain(200, ok);
        n_checks++;
        if (!ok || log_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rr_count: ok=%0d got %0d bytes required %0d", ok, log_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (log_q[k].idx != exp_q[k].idx || log_q[k].data !== exp_q[k].data) begin
                    n_fail++;
                    $display("FAIL rr_byte%0d: got %h from %0d required %h from %0d",
                             k, log_q[k].data, log_q[k].idx, exp_q[k].data, exp_q[k].idx);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            tb_enable = 1'b1;
            busy_mode = 2;
            for (int i = 0; i < NUM; i++)
                if (i == 3 || $urandom_range(0, 1) == 1)
                    repeat ($urandom_range(1, 3)) add_msg(i, $urandom_range(1, 4));
            build_exp();
            drive_srcs();
            drain(3000, ok);
            bad = 0;
            if (log_q.size() != exp_q.size()) bad++;
            else
                for (int k = 0; k < exp_q.size(); k++)
                    if (log_q[k].idx != exp_q[k].idx || log_q[k].data !== exp_q[k].data) bad++;
            n_checks++;
            if (!ok || bad != 0) begin
                n_fail++;
                $display("FAIL b2b_stream%0d: ok=%0d got %0d bytes required %0d, %0d wrong",
                         it, ok, log_q.size(), exp_q.size(), bad);
            end
            n_checks++;
            if (onehot_viol + ack_viol + busy_viol != 0 || to_q.size() != 0) begin
                n_fail++;
                $display("FAIL b2b_protocol%0d: onehot=%0d ack=%0d busy=%0d timeouts=%0d required all 0",
                         it, onehot_viol, ack_viol, busy_viol, to_q.size());
            end
        end
    endtask

    task automatic test_busy();
        bit ok;
        do_reset();
        tb_enable = 1'b1;
        busy_mode = 1;
        add_msg(2, 3);
        drive_srcs();
        drain(200, ok);
        n_checks++;
        if (!ok || log_q.size() != 3 || busy_viol != 0) begin
            n_fail++;
            $display("FAIL busy_stream: ok=%0d got %0d bytes, %0d under busy, required 3 and 0",
                     ok, log_q.size(), busy_viol);
        end else begin
            for (int k = 1; k < 3; k++) begin
                n_checks++;
                if (log_q[k].cyc - log_q[k-1].cyc != 21) begin
                    n_fail++;
                    $display("FAIL busy_gap%0d: got %0d cycles required 21", k, log_q[k].cyc - log_q[k-1].cyc);
                end
            end
        end
    endtask

    task automatic test_enable();
        bit ok;
        int granted;
        do_reset();
        tb_enable = 1'b0;
        src_q[1].push_back(9'h0D1);
        src_q[1].push_back(9'h1D2);
        drive_srcs();
        granted = 0;
        repeat (10) begin
            step();
            if (bus.grant != '0) granted++;
        end
        n_checks++;
        if (granted != 0 || log_q.size() != 0) begin
            n_fail++;
            $display("FAIL enable_gate: got %0d granted cycles, %0d bytes, required 0", granted, log_q.size());
        end
        tb_enable = 1'b1;
        step();
        n_checks++;
        if (bus.grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL enable_grant: got %b required 0010", bus.grant);
        end
        for (int n = 0; n < 10 && log_q.size() == 0; n++) step();
        tb_enable = 1'b0;
        drain(50, ok);
        n_checks++;
        if (!ok || log_q.size() != 2 || log_q[log_q.size()-1].data !== 8'hD2) begin
            n_fail++;
            $display("FAIL enable_midmsg: ok=%0d got %0d bytes required 2 ending D2", ok, log_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        do_reset();
        tb_enable = 1'b1;
        add_msg(0, 4);
        add_msg(1, 1);
        drive_srcs();
        for (int n = 0; n < 10 && log_q.size() == 0; n++) step();
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({bus.grant, bus.req_ack, bus.tx_data, bus.new_tx_data, bus.timeout} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got grant=%b ack=%b tx=%h strobe=%b, required all 0",
                     bus.grant, bus.req_ack, bus.tx_data, bus.new_tx_data);
        end
        rst = 1'b0;
        log_q.delete();
        build_exp();
        step();
        n_checks++;
        if (bus.grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_regrant: got %b required 0001", bus.grant);
        end
        drain(100, ok);
        bad = 0;
        if (log_q.size() != exp_q.size()) bad++;
        else
            for (int k = 0; k < exp_q.size(); k++)
                if (log_q[k].idx != exp_q[k].idx || log_q[k].data !== exp_q[k].data) bad++;
        n_checks++;
        if (!ok || bad != 0) begin
            n_fail++;
            $display("FAIL midreset_stream: ok=%0d got %0d bytes required %0d, %0d wrong",
                     ok, log_q.size(), exp_q.size(), bad);
        end
    endtask

`ifdef TX_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        do_reset();
        tb_enable = 1'b1;
        src_q[1].push_back(9'h0AA);
        src_q[2].push_back(9'h1BB);
        drive_srcs();
        for (int n = 0; n < 100 && to_q.size() == 0; n++) step();
        n_checks++;
        if (to_q.size() != 1 || log_q.size() != 1 || to_q[0] != log_q[0].cyc + 11) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %0d pulses after %0d bytes, required 1 pulse 11 cycles after the ack",
                     to_q.size(), log_q.size());
        end
        step();
        n_checks++;
        if (bus.grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL timeout_regrant: got %b required 0100", bus.grant);
        end
        drain(50, ok);
        n_checks++;
        if (!ok || log_q.size() != 2 || log_q[1].data !== 8'hBB || log_q[1].idx != 2) begin
            n_fail++;
            $display("FAIL timeout_next: ok=%0d got %0d bytes required 2 ending BB from 2", ok, log_q.size());
        end
    endtask
`endif

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        onehot_viol = 0;
        ack_viol    = 0;
        busy_viol   = 0;
        busy_mode   = 0;
        busy_cnt    = 0;
        tb_enable   = 1'b0;
        tb_busy     = 1'b0;
        tb_req      = '0;
        tb_last     = '0;
        tb_data     = '0;
        rst         = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_busy();
        test_enable();
        test_reset_mid();
`ifdef TX_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
